// File: rtl/wm_pkg.sv
// Shared types and defaults for the watermark block-fetch sequencer.
package wm_pkg;

    localparam int WM_ADDR_W = 21;
    localparam int WM_DIM_W  = 10;
    localparam int WM_BLK_W  = 7;
    localparam int WM_CNT_W  = 14;

    localparam logic WM_MODE_SEQ = 1'b0;
    localparam logic WM_MODE_ILV = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_FETCH = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } wm_state_e;

endpackage

// File: rtl/wm_blk_walker.sv
// Block/pixel position walker: holds r/c/br/bc and running offset pointers
// for the next beat to be issued; pure adds, no multiplier.
module wm_blk_walker
    import wm_pkg::*;
#(
    parameter int ADDR_W = WM_ADDR_W,
    parameter int DIM_W  = WM_DIM_W,
    parameter int BLK_W  = WM_BLK_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              step,
    input  logic              mode,
    input  logic [DIM_W-1:0]  np,
    input  logic [BLK_W-1:0]  m,
    input  logic [DIM_W-1:0]  bpr,
    output logic [ADDR_W-1:0] off,
    output logic              is_wm,
    output logic              last_blk,
    output logic              last_img
);

    logic [BLK_W-1:0]  r_q, r_d, c_q, c_d;
    logic [DIM_W-1:0]  br_q, br_d, bc_q, bc_d;
    logic              wm_q, wm_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, row_q, row_d, blk_q, blk_d;
    logic [ADDR_W-1:0] np_ext, m_ext;
    logic              pix_last, col_last, row_last;

    assign np_ext   = ADDR_W'(np);
    assign m_ext    = ADDR_W'(m);
    assign pix_last = (r_q == (m - BLK_W'(1))) && (c_q == (m - BLK_W'(1)));
    assign col_last = (bc_q == (bpr - DIM_W'(1)));
    assign row_last = (br_q == (bpr - DIM_W'(1)));
    assign off      = ptr_q;
    assign is_wm    = wm_q;
    assign last_blk = wm_q & pix_last;
    assign last_img = wm_q & pix_last & col_last & row_last;

    // Next position: phase switch, in-block pixel step, or block step
    always_comb begin
        r_d   = r_q;
        c_d   = c_q;
        br_d  = br_q;
        bc_d  = bc_q;
        wm_d  = wm_q;
        ptr_d = ptr_q;
        row_d = row_q;
        blk_d = blk_q;
        if (init) begin
            r_d   = '0;
            c_d   = '0;
            br_d  = '0;
            bc_d  = '0;
            wm_d  = 1'b0;
            ptr_d = '0;
            row_d = '0;
            blk_d = '0;
        end else if (step) begin
            if (!wm_q && (mode == WM_MODE_ILV)) begin
                wm_d = 1'b1;
            end else if (!wm_q && pix_last) begin
                wm_d  = 1'b1;
                r_d   = '0;
                c_d   = '0;
                row_d = blk_q;
                ptr_d = blk_q;
            end else if (wm_q && pix_last) begin
                wm_d = 1'b0;
                r_d  = '0;
                c_d  = '0;
                if (!col_last) begin
                    bc_d  = bc_q + DIM_W'(1);
                    blk_d = blk_q + m_ext;
                    row_d = blk_q + m_ext;
                    ptr_d = blk_q + m_ext;
                end else begin
                    // last row start of the rightmost block + M is the next block-row origin
                    bc_d  = '0;
                    br_d  = br_q + DIM_W'(1);
                    blk_d = row_q + m_ext;
                    row_d = row_q + m_ext;
                    ptr_d = row_q + m_ext;
                end
            end else begin
                if (mode == WM_MODE_ILV) begin
                    wm_d = 1'b0;
                end else begin
                    wm_d = wm_q;
                end
                if (c_q != (m - BLK_W'(1))) begin
                    c_d   = c_q + BLK_W'(1);
                    ptr_d = ptr_q + ADDR_W'(1);
                end else begin
                    c_d   = '0;
                    r_d   = r_q + BLK_W'(1);
                    row_d = row_q + np_ext;
                    ptr_d = row_q + np_ext;
                end
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Position and pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            c_q   <= '0;
            br_q  <= '0;
            bc_q  <= '0;
            wm_q  <= 1'b0;
            ptr_q <= '0;
            row_q <= '0;
            blk_q <= '0;
        end else begin
            r_q   <= r_d;
            c_q   <= c_d;
            br_q  <= br_d;
            bc_q  <= bc_d;
            wm_q  <= wm_d;
            ptr_q <= ptr_d;
            row_q <= row_d;
            blk_q <= blk_d;
        end
    end

endmodule

// File: rtl/wm_block_fetch_seq.sv
// Read-address sequencer for primary/watermark block pairs: configuration
// check by repeated subtraction, then one registered address per handshake.
module wm_block_fetch_seq
    import wm_pkg::*;
#(
    parameter int ADDR_W = WM_ADDR_W,
    parameter int DIM_W  = WM_DIM_W,
    parameter int BLK_W  = WM_BLK_W,
    parameter int CNT_W  = WM_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DIM_W-1:0]  cfg_np,
    input  logic [BLK_W-1:0]  cfg_m,
    input  logic [ADDR_W-1:0] cfg_prim_base,
    input  logic [ADDR_W-1:0] cfg_wm_base,
    input  logic              cfg_mode,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_is_wm,
    output logic              rd_last_blk,
    output logic              rd_last_img,
    output logic [CNT_W-1:0]  blk_idx,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    wm_state_e         state_q, state_d;
    logic [DIM_W-1:0]  np_q, np_d, acc_q, acc_d, bpr_q, bpr_d;
    logic [BLK_W-1:0]  m_q, m_d;
    logic [ADDR_W-1:0] pb_q, pb_d, wb_q, wb_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_valid_q, rd_valid_d, rd_is_wm_q, rd_is_wm_d;
    logic              rd_last_blk_q, rd_last_blk_d, rd_last_img_q, rd_last_img_d;
    logic [CNT_W-1:0]  blk_idx_q, blk_idx_d;
    logic              busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
    logic              walk_init, load_beat, cfg_bad;
    logic [ADDR_W-1:0] walk_off, beat_addr;
    logic              walk_is_wm, walk_last_blk, walk_last_img;

    wm_blk_walker #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W),
        .BLK_W  (BLK_W)
    ) u_walker (
        .clk      (clk),
        .rst      (rst),
        .init     (walk_init),
        .step     (load_beat),
        .mode     (mode_q),
        .np       (np_q),
        .m        (m_q),
        .bpr      (bpr_q),
        .off      (walk_off),
        .is_wm    (walk_is_wm),
        .last_blk (walk_last_blk),
        .last_img (walk_last_img)
    );

    // FSM next state, configuration check and output-register next values
    always_comb begin
        state_d       = state_q;
        np_d          = np_q;
        m_d           = m_q;
        pb_d          = pb_q;
        wb_d          = wb_q;
        mode_d        = mode_q;
        acc_d         = acc_q;
        bpr_d         = bpr_q;
        rd_addr_d     = rd_addr_q;
        rd_valid_d    = rd_valid_q;
        rd_is_wm_d    = rd_is_wm_q;
        rd_last_blk_d = rd_last_blk_q;
        rd_last_img_d = rd_last_img_q;
        blk_idx_d     = blk_idx_q;
        done_d        = 1'b0;
        cfg_err_d     = 1'b0;
        walk_init     = 1'b0;
        load_beat     = 1'b0;
        cfg_bad       = (m_q == BLK_W'(0)) || (np_q == DIM_W'(0)) || (DIM_W'(m_q) > np_q);
        beat_addr     = (walk_is_wm ? wb_q : pb_q) + walk_off;
        if (abort) begin
            state_d    = ST_IDLE;
            rd_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        np_d      = cfg_np;
                        m_d       = cfg_m;
                        pb_d      = cfg_prim_base;
                        wb_d      = cfg_wm_base;
                        mode_d    = cfg_mode;
                        acc_d     = cfg_np;
                        bpr_d     = DIM_W'(0);
                        blk_idx_d = CNT_W'(0);
                        walk_init = 1'b1;
                        state_d   = ST_CHECK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (cfg_bad) begin
                        state_d   = ST_ERR;
                        cfg_err_d = 1'b1;
                    end else if (acc_q == DIM_W'(m_q)) begin
                        bpr_d      = bpr_q + DIM_W'(1);
                        state_d    = ST_FETCH;
                        rd_valid_d = 1'b1;
                        load_beat  = 1'b1;
                    end else if (acc_q < DIM_W'(m_q)) begin
                        state_d   = ST_ERR;
                        cfg_err_d = 1'b1;
                    end else begin
                        acc_d = acc_q - DIM_W'(m_q);
                        bpr_d = bpr_q + DIM_W'(1);
                    end
                end
                ST_FETCH: begin
                    if (rd_ready) begin
                        if (rd_last_blk_q) begin
                            blk_idx_d = blk_idx_q + CNT_W'(1);
                        end else begin
                            blk_idx_d = blk_idx_q;
                        end
                        if (rd_last_img_q) begin
                            state_d    = ST_DONE;
                            rd_valid_d = 1'b0;
                            done_d     = 1'b1;
                        end else begin
                            load_beat = 1'b1;
                        end
                    end else begin
                        rd_valid_d = rd_valid_q;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                ST_ERR:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
        if (load_beat) begin
            rd_addr_d     = beat_addr;
            rd_is_wm_d    = walk_is_wm;
            rd_last_blk_d = walk_last_blk;
            rd_last_img_d = walk_last_img;
        end else begin
            rd_addr_d = rd_addr_q;
        end
        busy_d = (state_d == ST_CHECK) || (state_d == ST_FETCH);
    end

    // State, latched configuration and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            np_q          <= '0;
            m_q           <= '0;
            pb_q          <= '0;
            wb_q          <= '0;
            mode_q        <= WM_MODE_SEQ;
            acc_q         <= '0;
            bpr_q         <= '0;
            rd_addr_q     <= '0;
            rd_valid_q    <= 1'b0;
            rd_is_wm_q    <= 1'b0;
            rd_last_blk_q <= 1'b0;
            rd_last_img_q <= 1'b0;
            blk_idx_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            np_q          <= np_d;
            m_q           <= m_d;
            pb_q          <= pb_d;
            wb_q          <= wb_d;
            mode_q        <= mode_d;
            acc_q         <= acc_d;
            bpr_q         <= bpr_d;
            rd_addr_q     <= rd_addr_d;
            rd_valid_q    <= rd_valid_d;
            rd_is_wm_q    <= rd_is_wm_d;
            rd_last_blk_q <= rd_last_blk_d;
            rd_last_img_q <= rd_last_img_d;
            blk_idx_q     <= blk_idx_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign rd_addr     = rd_addr_q;
    assign rd_valid    = rd_valid_q;
    assign rd_is_wm    = rd_is_wm_q;
    assign rd_last_blk = rd_last_blk_q;
    assign rd_last_img = rd_last_img_q;
    assign blk_idx     = blk_idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;

endmodule
